// File: rtl/pc_gen.sv
`timescale 1ns/1ps
// Fetch address generator: sequential group advance, exception/branch redirects
// with an epoch tag, and a FAULT halt for misaligned redirect targets.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int          FETCH_WIDTH  = 1,
  parameter int          EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_ready,
  input  logic               exc_valid,
  input  logic [31:0]        exc_target,
  input  logic               br_valid,
  input  logic [31:0]        br_target,
  output logic               pc_valid,
  output logic [31:0]        pc_address,
  output logic [2:0]         fetch_count,
  output logic [EPOCH_W-1:0] epoch,
  output logic               alignment_error
);

  localparam logic [31:0] G_SIZE = 32'(FETCH_WIDTH * 4);
  localparam logic [31:0] G_MASK = G_SIZE - 32'd1;
  localparam logic [2:0]  FW_CNT = 3'(FETCH_WIDTH);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic        br_take, redirect, accept;
  logic [31:0] redir_target;

  // A branch never leaves FAULT; only an exception does.
  always_comb begin
    br_take      = br_valid && !exc_valid && (state != FAULT);
    redirect     = exc_valid || br_take;
    redir_target = exc_valid ? exc_target : br_target;
    accept       = pc_valid && fetch_ready && !redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = (redir_target[1:0] == 2'b00) ? RUN : FAULT;
    end else begin
      case (state)
        BOOT:    state_nxt = (RESET_VECTOR[1:0] == 2'b00) ? RUN : FAULT;
        RUN:     state_nxt = RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_valid        = (state == RUN);
    alignment_error = (state == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_address <= RESET_VECTOR;
      epoch      <= '0;
    end else if (redirect) begin
      pc_address <= redir_target;
      epoch      <= epoch + 1'b1;
    end else if (accept) begin
      pc_address <= (pc_address & ~G_MASK) + G_SIZE;
    end
  end

  // Slots remaining from pc_address to the end of its aligned group.
  assign fetch_count = FW_CNT - 3'((pc_address & G_MASK) >> 2);

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000: fetch address loaded at reset.
REQ-002 SHALL have parameter FETCH_WIDTH, default 1: instructions per fetch group; legal values 1, 2, 4.
REQ-003 SHALL have parameter EPOCH_W, default 2: width of the redirect epoch tag.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port fetch_ready  input  1  fetch stage accepts the current group.
REQ-008 SHALL have port exc_valid  input  1  exception redirect request.
REQ-009 SHALL have port exc_target  input  32  exception redirect address.
REQ-010 SHALL have port br_valid  input  1  branch redirect request.
REQ-011 SHALL have port br_target  input  32  branch redirect address.
REQ-012 SHALL have port pc_valid  output  1  pc_address holds a fetchable group.
REQ-013 SHALL have port pc_address  output  32  current fetch address.
REQ-014 SHALL have port fetch_count  output  3  valid slots from pc_address to the group end.
REQ-015 SHALL have port epoch  output  EPOCH_W  redirect generation tag.
REQ-016 SHALL have port alignment_error  output  1  pc_address is misaligned; fetch is halted.

Function
REQ-017 SHALL implement states BOOT, RUN and FAULT, all registered.
REQ-018 SHALL leave BOOT for RUN on the first clk edge after rst deasserts, when no redirect is active.
REQ-019 SHALL define G = FETCH_WIDTH*4 bytes; a group starts at an address aligned to G.
REQ-020 SHALL drive fetch_count = FETCH_WIDTH - pc_address[log2(G)-1:2]; fetch_count is 1 when FETCH_WIDTH=1.
REQ-021 SHALL drive pc_valid=1 only in RUN.
REQ-022 SHALL treat an accept as pc_valid && fetch_ready in a cycle with no redirect.
REQ-023 SHALL, on accept, load pc_address <= (pc_address & ~(G-1)) + G, modulo 2^32; 32'hFFFF_FFFC with G=4 advances to 0.
REQ-024 SHALL hold pc_address, fetch_count and epoch stable while pc_valid && !fetch_ready.
REQ-025 SHALL give exc_valid priority over br_valid when both are asserted in one cycle.
REQ-026 SHALL act on a redirect regardless of fetch_ready and in any state, except that br_valid is ignored in FAULT.
REQ-027 SHALL, on a redirect, load pc_address <= target on the next clk edge, discarding any stalled or sequential group.
REQ-028 SHALL, on a redirect, increment epoch by 1, wrapping modulo 2^EPOCH_W; no other event changes epoch.
REQ-029 SHALL, on a redirect with target[1:0]==0, enter RUN with pc_valid=1 on the next cycle.
REQ-030 SHALL, on a redirect with target[1:0]!=0, enter FAULT with alignment_error=1 and pc_valid=0 on the next cycle; pc_address shows the bad target.
REQ-031 SHALL hold FAULT, pc_address and alignment_error until exc_valid; only exc_valid leaves FAULT.
REQ-032 SHALL accept an exception redirect from BOOT and apply it as from RUN.
REQ-033 SHALL, if RESET_VECTOR[1:0]!=0, leave BOOT for FAULT instead of RUN.
REQ-034 SHALL have no combinational path from any input to pc_address, epoch or alignment_error; fetch_count is a function of pc_address only.

Reset
REQ-035 SHALL, while rst=1, force state=BOOT, pc_address=RESET_VECTOR, epoch=0, pc_valid=0, alignment_error=0, asynchronously.
REQ-036 SHALL, when rst asserts mid-stall or mid-FAULT, discard the pending group and return to the REQ-035 values immediately.
REQ-037 SHALL ignore redirect inputs while rst=1.

Verification
REQ-038 SHALL be verified by: reset release, fetch_ready=1, FETCH_WIDTH=1 -> cycle 1 pc_valid=1 at BFC0_0000, then BFC0_0004, BFC0_0008.
REQ-039 SHALL be verified by: FETCH_WIDTH=4, br_target=0000_1008, fetch_ready=1 -> pc 0000_1008 with count 2, then 0000_1010 with count 4, epoch +1.
REQ-040 SHALL be verified by: fetch_ready=0 for 3 cycles, then exc_valid and br_valid together (exc_target=8000_0180) -> pc holds during the stall, then 8000_0180 with epoch +1, branch dropped.
REQ-041 SHALL be verified by: br_target=0000_2002 -> FAULT, alignment_error=1, pc_valid=0; a later br_valid is ignored; exc_target=8000_0180 -> RUN at 8000_0180.
REQ-042 SHALL be verified by: EPOCH_W=2 with 5 redirects -> epoch 1,2,3,0,1; br_target=FFFF_FFFC, accept -> pc 0000_0000.
REQ-043 SHALL be verified by: rst asserted mid-stall with no clk edge -> outputs take the REQ-035 values at once.
